// File: rtl/cpu_step_controller.sv
// Processor step/run controller: divides the system clock down to a
// one-cycle cpu_en pulse every div_reg cycles in RUN mode, issues exactly
// one pulse per step_req rising edge in STEP mode, and holds in HALT.
// The divisor can only be changed while halted.
module cpu_step_controller #(
  parameter int unsigned N           = 9,
  parameter int unsigned DEFAULT_DIV = 500
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run_req,
  input  logic         halt_req,
  input  logic         step_req,
  input  logic         div_load,
  input  logic [N-1:0] div_value,
  output logic         cpu_en,
  output logic [1:0]   state,
  output logic [N-1:0] count,
  output logic         step_done,
  output logic         load_err
);

  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [N-1:0] r_count;
  logic [N-1:0] w_count_next;
  logic [N-1:0] r_div;
  logic [N-1:0] w_div_next;
  logic [N-1:0] w_div_m1;
  logic [N-1:0] w_div_load_val;

  logic         r_step_q;
  logic         w_step_edge;
  logic         w_active;
  logic         w_terminal;

  logic         r_cpu_en;
  logic         r_step_done;
  logic         r_load_err;
  logic         w_cpu_en_next;
  logic         w_step_done_next;
  logic         w_load_err_next;

  // Only a fresh rising edge of step_req may start a step.
  assign w_step_edge    = step_req & ~r_step_q;

  // Divisors below 2 cannot produce a meaningful period, so they clamp to 2.
  assign w_div_load_val = (div_value < N'(2)) ? N'(2) : div_value;
  assign w_div_m1       = r_div - N'(1);

  // Terminal uses >= so a counter that somehow overshot still wraps.
  assign w_active       = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_terminal     = w_active && (r_count >= w_div_m1);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; halt_req dominates in every state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_HALT: begin
        if (halt_req)         w_state_next = ST_HALT;
        else if (run_req)     w_state_next = ST_RUN;
        else if (w_step_edge) w_state_next = ST_STEP;
        else                  w_state_next = ST_HALT;
      end
      ST_RUN: begin
        if (halt_req) w_state_next = ST_HALT;
        else          w_state_next = ST_RUN;
      end
      ST_STEP: begin
        if (halt_req || w_terminal) w_state_next = ST_HALT;
        else                        w_state_next = ST_STEP;
      end
      default: w_state_next = ST_HALT;
    endcase
  end

  // Next values for counter, divisor and the registered pulse outputs.
  always_comb begin
    w_count_next     = '0;
    w_cpu_en_next    = 1'b0;
    w_step_done_next = 1'b0;
    w_load_err_next  = 1'b0;
    w_div_next       = r_div;

    unique case (r_state)
      ST_HALT: begin
        // Counter is already zero here, and entry into RUN/STEP starts at zero.
        w_count_next = '0;
        if (div_load) w_div_next = w_div_load_val;
      end
      ST_RUN, ST_STEP: begin
        w_load_err_next = div_load;
        if (halt_req) begin
          w_count_next = '0;
        end else if (w_terminal) begin
          w_count_next     = '0;
          w_cpu_en_next    = 1'b1;
          w_step_done_next = (r_state == ST_STEP);
        end else begin
          w_count_next = r_count + N'(1);
        end
      end
      default: begin
        w_count_next    = '0;
        w_load_err_next = div_load;
      end
    endcase
  end

  // Datapath and output pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_div       <= N'(DEFAULT_DIV);
      r_step_q    <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_step_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_div       <= w_div_next;
      r_step_q    <= step_req;
      r_cpu_en    <= w_cpu_en_next;
      r_step_done <= w_step_done_next;
      r_load_err  <= w_load_err_next;
    end
  end

  assign cpu_en    = r_cpu_en;
  assign step_done = r_step_done;
  assign load_err  = r_load_err;
  assign state     = r_state;
  assign count     = r_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: stimulus pushes the expected
// pulse events (cycle and flags); a negedge monitor pops and compares them.
module tb_cpu_step_controller;

  localparam int unsigned N = 9;

  logic         clock;
  logic         reset;
  logic         run_req;
  logic         halt_req;
  logic         step_req;
  logic         div_load;
  logic [N-1:0] div_value;
  logic         cpu_en;
  logic [1:0]   state;
  logic [N-1:0] count;
  logic         step_done;
  logic         load_err;

  cpu_step_controller #(.N(N), .DEFAULT_DIV(500)) dut (
    .clock     (clock),
    .reset     (reset),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .div_load  (div_load),
    .div_value (div_value),
    .cpu_en    (cpu_en),
    .state     (state),
    .count     (count),
    .step_done (step_done),
    .load_err  (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        en;
    logic        sd;
    logic        le;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic push(input int unsigned c, input logic en, input logic sd, input logic le);
    exp_t e;
    e.cyc = c; e.en = en; e.sd = sd; e.le = le;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned k);
    repeat (k) @(negedge clock);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && (cpu_en || step_done || load_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d: got en=%b sd=%b le=%b required no pulse",
                 cyc, cpu_en, step_done, load_err);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.en !== cpu_en || mon_e.sd !== step_done || mon_e.le !== load_err) begin
          errors++;
          $display("FAIL pulse: got cyc=%0d en=%b sd=%b le=%b required cyc=%0d en=%b sd=%b le=%b",
                   cyc, cpu_en, step_done, load_err, mon_e.cyc, mon_e.en, mon_e.sd, mon_e.le);
        end
      end
    end
  end

  int unsigned n;

  initial begin
    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    div_load = 1'b0; div_value = '0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_step_done", step_done, 0);
    check("rst_load_err", load_err, 0);
    reset = 1'b0;
    tick(1);

    // Free run with default divisor 500; rejected load mid-run.
    n = cyc; run_req = 1'b1;
    tick(100);
    div_load = 1'b1; div_value = 9'd7;
    push(n + 101, 1'b0, 1'b0, 1'b1);
    push(n + 501, 1'b1, 1'b0, 1'b0);
    push(n + 1001, 1'b1, 1'b0, 1'b0);
    tick(1); div_load = 1'b0;
    tick(999);
    halt_req = 1'b1; run_req = 1'b0;
    tick(1);
    check("run500_halt_state", state, 0);
    check("run500_halt_count", count, 0);
    halt_req = 1'b0;

    // Load 5 in HALT, single step.
    tick(1); div_load = 1'b1; div_value = 9'd5;
    tick(1); div_load = 1'b0;
    tick(1); n = cyc; step_req = 1'b1;
    push(n + 6, 1'b1, 1'b1, 1'b0);
    tick(2);
    check("step5_state_mid", state, 2);
    check("step5_count_mid", count, 1);
    tick(18);
    check("step5_state_end", state, 0);
    step_req = 1'b0;
    tick(1);

    // RUN with div 5, run_req dropped, halt at count 3.
    n = cyc; run_req = 1'b1;
    push(n + 6, 1'b1, 1'b0, 1'b0);
    push(n + 11, 1'b1, 1'b0, 1'b0);
    tick(1); run_req = 1'b0;
    tick(13);
    check("run5_state", state, 1);
    check("run5_count3", count, 3);
    halt_req = 1'b1;
    tick(1);
    check("run5_halt_state", state, 0);
    check("run5_halt_count", count, 0);
    halt_req = 1'b0;
    tick(5);

    // Load 1 -> clamped to 2; pulse every 2nd cycle; halt on the terminal count.
    div_load = 1'b1; div_value = 9'd1;
    tick(1); div_load = 1'b0;
    tick(1); n = cyc; run_req = 1'b1;
    push(n + 3, 1'b1, 1'b0, 1'b0);
    push(n + 5, 1'b1, 1'b0, 1'b0);
    push(n + 7, 1'b1, 1'b0, 1'b0);
    push(n + 9, 1'b1, 1'b0, 1'b0);
    tick(10);
    check("run2_count_term", count, 1);
    halt_req = 1'b1;
    tick(1);
    check("run2_halt_state", state, 0);
    halt_req = 1'b0; run_req = 1'b0;
    tick(3);

    // Divisor load coincident with step entry applies immediately.
    n = cyc; div_load = 1'b1; div_value = 9'd3; step_req = 1'b1;
    push(n + 4, 1'b1, 1'b1, 1'b0);
    tick(1); div_load = 1'b0;
    tick(6);
    check("step3_state_end", state, 0);
    step_req = 1'b0;
    tick(1);

    // Load 0 -> clamped to 2, step.
    div_load = 1'b1; div_value = 9'd0;
    tick(1); div_load = 1'b0;
    tick(1); n = cyc; step_req = 1'b1;
    push(n + 3, 1'b1, 1'b1, 1'b0);
    tick(5);
    step_req = 1'b0;
    tick(1);

    // Priority: halt beats run and step; run beats step.
    run_req = 1'b1; halt_req = 1'b1; step_req = 1'b1;
    tick(1);
    check("prio_halt_state", state, 0);
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    tick(1);
    run_req = 1'b1; step_req = 1'b1;
    tick(1);
    check("prio_run_state", state, 1);
    check("prio_run_count", count, 0);
    halt_req = 1'b1;
    tick(1);
    check("prio_halt2_state", state, 0);
    halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
    tick(2);

    // Reset mid-STEP aborts; held step_req restarts a step with divisor 500.
    div_load = 1'b1; div_value = 9'd5;
    tick(1); div_load = 1'b0;
    tick(1); n = cyc; step_req = 1'b1;
    tick(4);
    check("abort_state_step", state, 2);
    check("abort_count3", count, 3);
    reset = 1'b1;
    #1;
    check("abort_state", state, 0);
    check("abort_count", count, 0);
    check("abort_cpu_en", cpu_en, 0);
    check("abort_step_done", step_done, 0);
    check("abort_load_err", load_err, 0);
    tick(1);
    n = cyc; reset = 1'b0;
    push(n + 501, 1'b1, 1'b1, 1'b0);
    tick(510);
    check("post_rst_state", state, 0);
    step_req = 1'b0;
    tick(3);

    check("pending_events", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
